// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: operand-forward selects and memory-wait FSM states.
// Pure definitions; no latency, no backpressure.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding select for the E stage; M result beats W result, x0 never forwards.
// Combinational, zero latency; no backpressure.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic [REG_AW-1:0] rs_e_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: forwarding, load-use stall, branch flush, memory-wait freeze with timeout, perf counters.
// Stall/flush/forward outputs are combinational (zero latency); a not-ready memory freezes all five stages.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              mem_req_M,
    input  logic              mem_ready,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int               WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    mem_state_e       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       mem_stall, lu, freeze;
    logic [4:0] stall_vec;
    logic       flush_d, flush_e, br_flush;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .rd_m_i        (RD_M),
        .rd_w_i        (RD_W),
        .rs_e_i        (Rs1_E),
        .fwd_o         (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .rd_m_i        (RD_M),
        .rd_w_i        (RD_W),
        .rs_e_i        (Rs2_E),
        .fwd_o         (fwd_b)
    );

    assign mem_stall = mem_req_M && !mem_ready;
    assign lu        = LoadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    assign freeze    = (state_q == ERR) || mem_stall;

    // Dropping the request while waiting releases the FSM exactly like a ready response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Branch outranks load-use: the load-use victim sits in D and is flushed anyway.
    always_comb begin
        stall_vec = '0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        br_flush  = 1'b0;
        if (!rst) begin
            stall_vec = '0;
        end else if (freeze) begin
            stall_vec = '1;
        end else if (PCSrcE) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            br_flush = 1'b1;
        end else if (lu) begin
            stall_vec = 5'b11000;
            flush_e   = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_vec[4] && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ForwardAE = rst ? fwd_a : FWD_RF;
    assign ForwardBE = rst ? fwd_b : FWD_RF;
    assign {StallF, StallD, StallE, StallM, StallW} = stall_vec;
    assign FlushD    = flush_d;
    assign FlushE    = flush_e;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (16-bit and 2-bit counters, timeout 4) share one stimulus stream.
// Expected values come from a cycle-level model of the hazard rules (consecutive-wait count, sticky error).
module tb_hazard_ctrl_unit;

    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, mem_req_M, mem_ready;
    logic [4:0] RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D;

    logic [1:0]  ForwardAE, ForwardBE, ForwardAE_s, ForwardBE_s;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_err;
    logic        StallF_s, StallD_s, StallE_s, StallM_s, StallW_s, FlushD_s, FlushE_s, mem_err_s;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit          err_m   = 1'b0;
    int          consec_m = 0;
    longint      stall_m = 0;
    longint      flush_m = 0;
    logic [10:0] exp_ctrl;
    bit          exp_brf;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MEM_TIMEOUT(MT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_unit #(.REG_AW(5), .MEM_TIMEOUT(MT), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s),
        .StallF(StallF_s), .StallD(StallD_s), .StallE(StallE_s), .StallM(StallM_s), .StallW(StallW_s),
        .FlushD(FlushD_s), .FlushE(FlushE_s), .mem_err(mem_err_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    function automatic logic [10:0] obs_ctrl();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};
    endfunction

    function automatic logic [10:0] obs_ctrl_s();
        return {ForwardAE_s, ForwardBE_s, StallF_s, StallD_s, StallE_s, StallM_s, StallW_s, FlushD_s, FlushE_s};
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [1:0] sat2(input longint v);
        return (v > 3) ? 2'd3 : v[1:0];
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rst = 1'b1; RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
        mem_req_M = 1'b0; mem_ready = 1'b0;
        RD_M = '0; RD_W = '0; RD_E = '0; Rs1_E = '0; Rs2_E = '0; Rs1_D = '0; Rs2_D = '0;
    endtask

    // Moves to the falling edge and derives the expected control outputs for this cycle.
    task automatic settle();
        bit ms, lu;
        @(negedge clk);
        ms = mem_req_M && !mem_ready;
        lu = LoadE && RD_E != 5'd0 && (RD_E == Rs1_D || RD_E == Rs2_D);
        exp_ctrl = '0;
        exp_brf  = 1'b0;
        if (rst) begin
            exp_ctrl[10:9] = ref_fwd(Rs1_E);
            exp_ctrl[8:7]  = ref_fwd(Rs2_E);
            if (err_m || ms) begin
                exp_ctrl[6:2] = 5'b11111;
            end else if (PCSrcE) begin
                exp_ctrl[1:0] = 2'b11;
                exp_brf = 1'b1;
            end else if (lu) begin
                exp_ctrl[6:5] = 2'b11;
                exp_ctrl[0]   = 1'b1;
            end
        end
    endtask

    // Applies this cycle to the model, then crosses the rising edge.
    task automatic tick();
        if (!rst) begin
            err_m = 1'b0; consec_m = 0; stall_m = 0; flush_m = 0;
        end else begin
            if (exp_ctrl[6]) stall_m++;
            if (exp_brf) flush_m++;
            if (mem_req_M && !mem_ready) begin
                consec_m++;
                if (consec_m >= MT) err_m = 1'b1;
            end else begin
                consec_m = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_req_M = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
        RegWriteM = 1'b1; RD_M = 5'd3; Rs1_E = 5'd3;
        settle();
        n_cmp++;
        if ({obs_ctrl(), obs_ctrl_s()} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b/%b required all zero", obs_ctrl(), obs_ctrl_s());
        end
        tick();
        n_cmp++;
        if ({stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s, mem_err, mem_err_s} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%0d flush=%0d err=%b required 0", stall_cnt, flush_cnt, mem_err);
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWriteM = 1'b1; RD_M = 5'd5; RegWriteW = 1'b1; RD_W = 5'd5; Rs1_E = 5'd5; Rs2_E = 5'd0;
        settle();
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fwd_m_priority: got A=%b B=%b required A=10 B=00", ForwardAE, ForwardBE);
        end
        tick();
        RegWriteM = 1'b0;
        settle();
        n_cmp++;
        if (ForwardAE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_w: got A=%b required 01", ForwardAE);
        end
        tick();
        for (int i = 0; i < 24; i++) begin
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            RD_M = 5'($urandom_range(0, 3)); RD_W = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            settle();
            n_cmp++;
            if ({obs_ctrl(), obs_ctrl_s()} !== {exp_ctrl, exp_ctrl}) begin
                n_fail++;
                $display("FAIL fwd_rand[%0d]: got %b required %b", i, obs_ctrl(), exp_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        longint base_s, base_f;
        clear_inputs();
        base_s = stall_m;
        LoadE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
        settle();
        n_cmp++;
        if (obs_ctrl() !== 11'b0000_11000_01) begin
            n_fail++;
            $display("FAIL load_use: got %b required 00001100001", obs_ctrl());
        end
        tick();
        LoadE = 1'b0; RegWriteM = 1'b1; RD_M = 5'd7;
        settle();
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_once: got F=%b D=%b FE=%b required 000", StallF, StallD, FlushE);
        end
        tick();
        base_f = flush_m;
        LoadE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7; PCSrcE = 1'b1; RegWriteM = 1'b0;
        settle();
        n_cmp++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            n_fail++;
            $display("FAIL branch_over_lu: got SF=%b SD=%b FD=%b FE=%b required 0011", StallF, StallD, FlushD, FlushE);
        end
        tick();
        n_cmp++;
        if (stall_cnt !== sat16(base_s + 1) || flush_cnt !== sat16(base_f + 1)) begin
            n_fail++;
            $display("FAIL lu_counters: got stall=%0d flush=%0d required %0d/%0d", stall_cnt, flush_cnt, base_s + 1, base_f + 1);
        end
    endtask

    task automatic test_mem_wait();
        longint base_s;
        clear_inputs();
        base_s = stall_m;
        mem_req_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++;
            if ({obs_ctrl(), obs_ctrl_s()} !== {11'b0000_11111_00, 11'b0000_11111_00}) begin
                n_fail++;
                $display("FAIL mem_wait_stall[%0d]: got %b required 00001111100", i, obs_ctrl());
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        n_cmp++;
        if (obs_ctrl() !== 11'd0) begin
            n_fail++;
            $display("FAIL mem_ready_release: got %b required 0", obs_ctrl());
        end
        tick();
        n_cmp++;
        if (stall_cnt !== sat16(base_s + 3) || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_wait_cnt: got stall=%0d err=%b required %0d err=0", stall_cnt, mem_err, base_s + 3);
        end
        // two waits, a dropped request, then three more: the wait count must restart
        mem_req_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_req_M = (i != 2);
            settle();
            n_cmp++;
            if ({obs_ctrl(), obs_ctrl_s()} !== {exp_ctrl, exp_ctrl} || StallW !== (i != 2)) begin
                n_fail++;
                $display("FAIL mem_req_drop[%0d]: got %b required %b", i, obs_ctrl(), exp_ctrl);
            end
            tick();
        end
        n_cmp++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_restart: got err=%b required 0", mem_err);
        end
        mem_req_M = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_branch_freeze();
        longint base_f;
        clear_inputs();
        base_f = flush_m;
        mem_req_M = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
        settle();
        n_cmp++;
        if (obs_ctrl() !== 11'b0000_11111_00) begin
            n_fail++;
            $display("FAIL freeze_over_branch: got %b required 00001111100", obs_ctrl());
        end
        tick();
        mem_ready = 1'b1;
        settle();
        n_cmp++;
        if (obs_ctrl() !== 11'b0000_00000_11) begin
            n_fail++;
            $display("FAIL branch_after_release: got %b required 00000000011", obs_ctrl());
        end
        tick();
        n_cmp++;
        if (flush_cnt !== sat16(base_f + 1)) begin
            n_fail++;
            $display("FAIL branch_flush_cnt: got %0d required %0d", flush_cnt, base_f + 1);
        end
    endtask

    task automatic test_timeout();
        clear_inputs();
        mem_req_M = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= MT; i++) begin
            settle();
            tick();
            n_cmp++;
            if ({mem_err, mem_err_s} !== {2{i == MT}}) begin
                n_fail++;
                $display("FAIL timeout_err[%0d]: got %b required %b", i, mem_err, (i == MT));
            end
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_req_M = (i == 0);
            settle();
            n_cmp++;
            if (obs_ctrl() !== 11'b0000_11111_00 || mem_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky[%0d]: got %b err=%b required 00001111100 err=1", i, obs_ctrl(), mem_err);
            end
            tick();
        end
        rst = 1'b0;
        settle();
        tick();
        rst = 1'b1; mem_req_M = 1'b0;
        settle();
        n_cmp++;
        if (obs_ctrl() !== 11'd0 || mem_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b err=%b stall=%0d required 0", obs_ctrl(), mem_err, stall_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        rst = 1'b0;
        settle();
        tick();
        rst = 1'b1; LoadE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++;
            if ({StallF_s, StallD_s, FlushE_s} !== 3'b111) begin
                n_fail++;
                $display("FAIL sat_stall[%0d]: got %b%b%b required 111", i, StallF_s, StallD_s, FlushE_s);
            end
            tick();
        end
        n_cmp++;
        if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL saturate: got small=%0d wide=%0d required 3/5", stall_cnt_s, stall_cnt);
        end
        rst = 1'b0;
        settle();
        n_cmp++;
        if ({obs_ctrl(), obs_ctrl_s()} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %b required 0", obs_ctrl_s());
        end
        tick();
        n_cmp++;
        if ({stall_cnt, stall_cnt_s, flush_cnt, flush_cnt_s} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d required 0", stall_cnt, stall_cnt_s);
        end
        rst = 1'b1;
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) != 0);
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            LoadE     = ($urandom_range(0, 2) == 0);
            PCSrcE    = ($urandom_range(0, 6) == 0);
            mem_req_M = ($urandom_range(0, 2) == 0);
            mem_ready = 1'($urandom);
            RD_M  = 5'($urandom_range(0, 7)); RD_W  = 5'($urandom_range(0, 7));
            RD_E  = 5'($urandom_range(0, 7)); Rs1_E = 5'($urandom_range(0, 7));
            Rs2_E = 5'($urandom_range(0, 7)); Rs1_D = 5'($urandom_range(0, 7));
            Rs2_D = 5'($urandom_range(0, 7));
            settle();
            n_cmp++;
            if ({obs_ctrl(), obs_ctrl_s()} !== {exp_ctrl, exp_ctrl}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got %b/%b required %b", i, obs_ctrl(), obs_ctrl_s(), exp_ctrl);
            end
            tick();
            n_cmp++;
            if ({stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s, mem_err, mem_err_s} !==
                {sat16(stall_m), sat16(flush_m), sat2(stall_m), sat2(flush_m), err_m, err_m}) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got stall=%0d flush=%0d err=%b required %0d/%0d/%b",
                         i, stall_cnt, flush_cnt, mem_err, stall_m, flush_m, err_m);
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch_freeze();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Second-generation pipeline hazard controller for the 5-stage RISC-V core. It keeps M/W operand forwarding and adds four things:
- load-use stall detection
- taken-branch flush
- a data-memory wait FSM that freezes the pipeline, with a timeout watchdog
- saturating performance counters

Sits beside the datapath and drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers, plus the E-stage operand muxes.

Parameters:
REG_AW, 5, register-address width
MEM_TIMEOUT, 16, max consecutive memory-wait cycles before error (≥2)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
RegWriteM  in  1  M-stage instruction writes the register file
RegWriteW  in  1  W-stage instruction writes the register file
RD_M  in  REG_AW  M-stage destination register
RD_W  in  REG_AW  W-stage destination register
RD_E  in  REG_AW  E-stage destination register
Rs1_E, Rs2_E  in  REG_AW each  E-stage source registers
Rs1_D, Rs2_D  in  REG_AW each  D-stage source registers
LoadE  in  1  E-stage instruction is a load
PCSrcE  in  1  branch/jump taken, resolved in E
mem_req_M  in  1  M-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2 each  operand mux selects: 00 regfile, 01 W, 10 M
StallF, StallD, StallE, StallM, StallW  out  1 each  hold the stage register
FlushD, FlushE  out  1 each  insert bubble into D / E
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with StallF=1
flush_cnt  out  CNT_W  cycles with branch-caused FlushD=1

Behaviour:
- Reset (rst=0 at a rising edge):
  - FSM goes to RUN; wait_cnt=0; counters=0; mem_err=0.
  - While rst=0, every control output is forced to 0 (Forward*=00, all Stall*/Flush*=0).
- Forwarding, combinational, per operand:
  - 10 if RegWriteM && RD_M≠0 && RD_M==Rs_E.
  - Else 01 if RegWriteW && RD_W≠0 && RD_W==Rs_E.
  - Else 00. M has priority over W.
  - Forwarding stays active during freezes; the stage contents are held, so the selects remain consistent.
- Hazard terms:
  - mem_stall = mem_req_M && !mem_ready
  - lu = LoadE && RD_E≠0 && (RD_E==Rs1_D || RD_E==Rs2_D)
- Priority, highest first:
  - freeze (ERR state, or mem_stall in RUN/WAIT): all five Stall*=1, FlushD=FlushE=0. A branch or load-use held in the frozen pipe is re-evaluated after release. The W hold repeats the same regfile write, which is idempotent.
  - branch (PCSrcE): FlushD=1, FlushE=1, no stalls. This overrides lu, because the load-use victim in D is being flushed anyway.
  - load-use (lu): StallF=StallD=1, FlushE=1. Single bubble; a load in M then forwards via 10.
  - otherwise all 0.
- FSM (registered):
  - RUN: mem_stall → WAIT with wait_cnt=1.
  - WAIT: mem_ready=1 → RUN with wait_cnt=0; the access completes this cycle and no stall is asserted. Otherwise wait_cnt++. If wait_cnt==MEM_TIMEOUT-1 while still not ready → ERR and mem_err=1.
  - ERR: freeze forever; only reset exits.
- Timing details:
  - Stall assertion on the first not-ready cycle is combinational (zero latency).
  - mem_err rises on the edge that ends cycle MEM_TIMEOUT of waiting.
  - mem_req_M dropping while in WAIT is treated like mem_ready → RUN.
- Counters:
  - Increment at the clock edge when the condition held in that cycle.
  - Saturate at 2^CNT_W-1, no wrap.
  - flush_cnt counts only PCSrcE-caused flushes, not load-use FlushE.

Decomposition:
- hazard_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - FSM state encoding RUN/WAIT/ERR
- Sub-module fwd_sel: pure combinational single-operand forwarding decision, instantiated twice (A and B).
- FSM, priority logic and counters stay in hazard_ctrl_unit.

Test Plan:
- RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5, Rs2_E=0 → ForwardAE=10, ForwardBE=00. Then RegWriteM=0 → ForwardAE=01.
- LoadE=1, RD_E=7, Rs2_D=7, PCSrcE=0 → StallF=StallD=FlushE=1 for exactly one cycle. Repeat with PCSrcE=1 → FlushD=FlushE=1, StallF=0, stall_cnt unchanged.
- mem_req_M=1 with mem_ready low for 3 cycles, then high → all Stall*=1 for 3 cycles, 0 on the ready cycle. stall_cnt +3, FSM back in RUN, mem_err=0.
- MEM_TIMEOUT=4, mem_ready held low → mem_err=1 after the 4th wait cycle. Stalls stay 1 even after mem_ready rises; rst=0 for one edge clears all.
- mem_stall and PCSrcE=1 in the same cycle → stalls only, FlushD=0. The flush appears on the cycle mem_ready=1 releases the freeze, and flush_cnt increments by 1.
- CNT_W=2, 5 consecutive load-use stall cycles → stall_cnt saturates at 3; rst=0 mid-stall → all outputs 0 and counters 0 after that edge.
